// File: rtl/seq_feeder_pkg.sv
// seq_feeder_pkg: shared definitions for the systolic-array sequence feeder.
//   - base code constants (BASE_A..BASE_N, BASE_PAD)
//   - feeder FSM state encoding (enum plus legacy 2-bit constants)
//   - run_len(): number of RUN cycles for an L-base pair on B lanes
package seq_feeder_pkg;

  localparam logic [2:0] BASE_PAD = 3'd0;
  localparam logic [2:0] BASE_A   = 3'd1;
  localparam logic [2:0] BASE_C   = 3'd2;
  localparam logic [2:0] BASE_G   = 3'd3;
  localparam logic [2:0] BASE_T   = 3'd4;
  localparam logic [2:0] BASE_N   = 3'd5;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FULL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Plain 2-bit constants so the state register stays a plain logic vector.
  localparam logic [1:0] S_LOAD = ST_LOAD;
  localparam logic [1:0] S_FULL = ST_FULL;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  // Every base of both sequences has to cross all B lanes, with one
  // injection every second cycle.
  function automatic int run_len(input int l, input int b);
    return 2 * l + b - 1;
  endfunction

endpackage

// File: rtl/seq_feeder_if.sv
// seq_feeder_if: load/run bus between the sequence source, seq_feeder and the
// PE array.
//   master (source / observer side): drives ld_valid, ld_data, start
//   slave  (seq_feeder side)       : drives ld_ready, loaded, busy, done,
//                                    ctr, R, Q
//   R/Q pack B lanes of W bits; lane k = bits [k*W +: W].
interface seq_feeder_if
  import seq_feeder_pkg::*;
#(
  parameter int B = 4,
  parameter int W = 3
);
  logic           ld_valid;
  logic           ld_ready;
  logic [W-1:0]   ld_data;
  logic           start;
  logic           loaded;
  logic           busy;
  logic           done;
  logic [7:0]     ctr;
  logic [B*W-1:0] R;
  logic [B*W-1:0] Q;

  modport master (
    output ld_valid, ld_data, start,
    input  ld_ready, loaded, busy, done, ctr, R, Q
  );

  modport slave (
    input  ld_valid, ld_data, start,
    output ld_ready, loaded, busy, done, ctr, R, Q
  );
endinterface

// File: rtl/seq_feeder_bank.sv
// seq_bank: storage for one reference/query pair of L bases each.
//   clk, reset : clock, asynchronous active-low reset (clears pointer/full)
//   we, wdata  : accepted load beat; beats 0..L-1 fill ref, L..2L-1 fill qry
//   clr        : discard the held pair (pointer and full flag to zero)
//   full       : all 2L beats are held
//   last       : the write pointer sits on the final beat slot
//   rd_addr    : combinational random read of ref/qry at the same index
module seq_bank
  import seq_feeder_pkg::*;
#(
  parameter int L  = 8,
  parameter int W  = 3,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          clr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          last,
  output logic [W-1:0]  rd_ref,
  output logic [W-1:0]  rd_qry
);
  localparam int PW = $clog2(2 * L);

  logic [PW-1:0] ptr;
  logic [W-1:0]  ref_mem [L];
  logic [W-1:0]  qry_mem [L];

  assign last = (ptr == PW'(2 * L - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr  <= '0;
      full <= 1'b0;
    end else if (clr) begin
      ptr  <= '0;
      full <= 1'b0;
    end else if (we) begin
      if (last) begin
        ptr  <= '0;
        full <= 1'b1;
      end else begin
        ptr <= ptr + PW'(1);
      end
    end
  end

  // Base storage carries no reset; the full flag alone decides validity.
  always_ff @(posedge clk) begin
    if (we) begin
      if (ptr < PW'(L)) ref_mem[AW'(ptr)] <= wdata;
      else              qry_mem[AW'(ptr - PW'(L))] <= wdata;
    end
  end

  assign rd_ref = ref_mem[rd_addr];
  assign rd_qry = qry_mem[rd_addr];

endmodule

// File: rtl/seq_feeder.sv
// seq_feeder: buffers one reference and one query sequence of L W-bit bases,
// then drives ctr/R/Q of the systolic PE array for one alignment run.
// Reference bases enter lane 0 and climb, query bases enter lane B-1 and
// descend, one injection every second cycle, giving the anti-diagonal
// wavefront.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   bus        : seq_feeder_if.slave (load handshake, start, status, ctr/R/Q)
// Build option: define SEQ_FEEDER_DBUF_EN for two banks, so the next pair can
// be loaded while the current one runs; banks swap on start.
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int B = 4,
  parameter int L = 8,
  parameter int W = 3
) (
  input logic         clk,
  input logic         reset,
  seq_feeder_if.slave bus
);
  localparam int         AW       = (L > 1) ? $clog2(L) : 1;
  localparam int         RUN_LEN  = run_len(L, B);
  localparam logic [7:0] CTR_LAST = 8'(RUN_LEN - 1);
  localparam int         LW       = (B - 1) * W;

  logic [1:0]     state, state_nxt;
  logic [7:0]     ctr_p0, ctr_nxt;
  logic [B*W-1:0] r_sr_p0, q_sr_p0;
  logic           busy_p0, done_p0, loaded_p0, loaded_nxt;
  logic           ld_ready, wr_fire, fill_done, start_ok, run_last, inj;
  logic [AW-1:0]  rd_addr;
  logic [W-1:0]   rd_ref, rd_qry, inj_r, inj_q;

  assign ctr_nxt  = ctr_p0 + 8'd1;
  assign start_ok = (state == S_FULL) && bus.start;
  assign run_last = (ctr_p0 == CTR_LAST);

  // Next cycle injects a base when it is even and bases remain; the start
  // edge always injects base 0.
  assign inj     = (state == S_RUN) ? (!ctr_nxt[0] && (ctr_nxt[7:1] < 7'(L))) : 1'b1;
  assign rd_addr = (state == S_RUN) ? AW'(ctr_nxt[7:1]) : '0;
  assign inj_r   = inj ? rd_ref : W'(BASE_PAD);
  assign inj_q   = inj ? rd_qry : W'(BASE_PAD);

`ifdef SEQ_FEEDER_DBUF_EN
  // act = bank feeding the PE array; loads always target the other bank.
  logic       act, rd_sel, inact_full;
  logic [1:0] bk_we, bk_clr, bk_full, bk_last;
  logic [W-1:0] bk_ref [2];
  logic [W-1:0] bk_qry [2];

  for (genvar i = 0; i < 2; i++) begin : g_bank
    seq_bank #(.L(L), .W(W), .AW(AW)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .we      (bk_we[i]),
      .clr     (bk_clr[i]),
      .wdata   (bus.ld_data),
      .rd_addr (rd_addr),
      .full    (bk_full[i]),
      .last    (bk_last[i]),
      .rd_ref  (bk_ref[i]),
      .rd_qry  (bk_qry[i])
    );
  end

  assign ld_ready   = !bk_full[~act];
  assign wr_fire    = bus.ld_valid && ld_ready;
  assign bk_we      = {wr_fire && !act, wr_fire && act};
  assign bk_clr     = {(state == S_DONE) && act, (state == S_DONE) && !act};
  assign fill_done  = wr_fire && bk_last[~act];
  assign inact_full = bk_full[~act] || fill_done;
  // While waiting in FULL the pair about to run is still the inactive bank.
  assign rd_sel     = (state == S_FULL) ? ~act : act;
  assign rd_ref     = bk_ref[rd_sel];
  assign rd_qry     = bk_qry[rd_sel];
  // After a swap the new inactive bank is the one cleared by the last DONE.
  assign loaded_nxt = start_ok ? 1'b0 : inact_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        act <= 1'b0;
    else if (start_ok) act <= ~act;
  end
`else
  logic bk_full, bk_last;

  seq_bank #(.L(L), .W(W), .AW(AW)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_fire),
    .clr     (state == S_DONE),
    .wdata   (bus.ld_data),
    .rd_addr (rd_addr),
    .full    (bk_full),
    .last    (bk_last),
    .rd_ref  (rd_ref),
    .rd_qry  (rd_qry)
  );

  assign ld_ready   = (state == S_LOAD) && !bk_full;
  assign wr_fire    = bus.ld_valid && ld_ready;
  assign fill_done  = wr_fire && bk_last;
  assign loaded_nxt = (state_nxt == S_FULL);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (fill_done) state_nxt = S_FULL;
      S_FULL: if (bus.start) state_nxt = S_RUN;
      S_RUN:  if (run_last)  state_nxt = S_DONE;
      default: begin
`ifdef SEQ_FEEDER_DBUF_EN
        state_nxt = inact_full ? S_FULL : S_LOAD;
`else
        state_nxt = S_LOAD;
`endif
      end
    endcase
  end

  // Stage p0: registered run counter and lane shift chains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_LOAD;
      loaded_p0 <= 1'b0;
      busy_p0   <= 1'b0;
      done_p0   <= 1'b0;
      ctr_p0    <= '0;
      r_sr_p0   <= '0;
      q_sr_p0   <= '0;
    end else begin
      state     <= state_nxt;
      loaded_p0 <= loaded_nxt;
      done_p0   <= 1'b0;
      if (start_ok) begin
        busy_p0 <= 1'b1;
        ctr_p0  <= '0;
        r_sr_p0 <= {{LW{1'b0}}, inj_r};
        q_sr_p0 <= {inj_q, {LW{1'b0}}};
      end else if (state == S_RUN) begin
        if (run_last) begin
          busy_p0 <= 1'b0;
          done_p0 <= 1'b1;
          ctr_p0  <= '0;
          r_sr_p0 <= '0;
          q_sr_p0 <= '0;
        end else begin
          ctr_p0  <= ctr_nxt;
          r_sr_p0 <= {r_sr_p0[LW-1:0], inj_r};
          q_sr_p0 <= {inj_q, q_sr_p0[B*W-1:W]};
        end
      end
    end
  end

  assign bus.ld_ready = ld_ready;
  assign bus.loaded   = loaded_p0;
  assign bus.busy     = busy_p0;
  assign bus.done     = done_p0;
  assign bus.ctr      = ctr_p0;
  assign bus.R        = r_sr_p0;
  assign bus.Q        = q_sr_p0;

endmodule

// File: tb/tb_seq_feeder.sv
// tb_seq_feeder: self-checking bench for seq_feeder (B=4, L=8, W=3).
`timescale 1ns/1ps
module tb_seq_feeder;
  import seq_feeder_pkg::*;

  localparam int B  = 4;
  localparam int L  = 8;
  localparam int W  = 3;
  localparam int RL = 2 * L + B - 1;

  typedef logic [W-1:0] seq_t [L];
  typedef struct {
    logic [7:0]     ctr;
    logic [B*W-1:0] r;
    logic [B*W-1:0] q;
  } exp_t;
  typedef struct {
    int             c;
    logic [B*W-1:0] r;
    logic [B*W-1:0] q;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  seq_feeder_if #(.B(B), .W(W)) bus ();

  seq_feeder #(.B(B), .L(L), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t sb[$];
  logic [B*W-1:0] obs_r [RL];
  logic [B*W-1:0] obs_q [RL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Lane contents straight from the wavefront definition.
  function automatic logic [B*W-1:0] lanes(input seq_t s, input int c, input bit is_q);
    logic [B*W-1:0] v;
    v = '0;
    for (int k = 0; k < B; k++) begin
      int d;
      d = c - (is_q ? (B - 1 - k) : k);
      if (d >= 0 && (d % 2) == 0 && (d / 2) < L) v[k*W +: W] = s[d / 2];
    end
    return v;
  endfunction

  // Called at a falling edge; returns at the falling edge after the final beat.
  task automatic load_pair(input seq_t rf, input seq_t qy, input bit stall, input bit start_last);
    int beat;
    int guard;
    bit fire;
    beat  = 0;
    guard = 0;
    while (beat < 2 * L && guard < 400) begin
      guard++;
      bus.ld_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.ld_data  = !bus.ld_valid ? 3'd7 : ((beat < L) ? rf[beat] : qy[beat - L]);
      fire = bus.ld_valid && bus.ld_ready;
      if (fire && beat == 2 * L - 1) begin
        check("loaded_before_last_beat", bus.loaded, 0);
        if (start_last) bus.start = 1'b1;
      end
      @(negedge clk);
      if (start_last) bus.start = 1'b0;
      if (fire) beat++;
    end
    bus.ld_valid = 1'b0;
    check("load_beats", beat, 2 * L);
    check("loaded_after_last_beat", bus.loaded, 1);
    check("ld_ready_when_full", bus.ld_ready, 0);
    if (start_last) begin
      @(negedge clk);
      check("start_on_last_beat_ignored", bus.busy, 0);
    end
  endtask

  // Called at a falling edge with a pair held; abort_at >= 0 resets mid-run.
  task automatic run_pair(input seq_t rf, input seq_t qy, input int abort_at, input bit exp_next_loaded);
    exp_t e;
    int busy_cnt;
    int guard;
    busy_cnt = 0;
    guard    = 0;
    check("loaded_before_start", bus.loaded, 1);
    bus.start = 1'b1;
    for (int c = 0; c < RL; c++) sb.push_back('{ctr: 8'(c), r: lanes(rf, c, 1'b0), q: lanes(qy, c, 1'b1)});
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy && sb.size() > 0 && guard < 4 * RL) begin
      guard++;
      e = sb.pop_front();
      check($sformatf("ctr_c%0d", e.ctr), bus.ctr, e.ctr);
      check($sformatf("R_c%0d", e.ctr), bus.R, e.r);
      check($sformatf("Q_c%0d", e.ctr), bus.Q, e.q);
      check($sformatf("done_low_c%0d", e.ctr), bus.done, 0);
`ifndef SEQ_FEEDER_DBUF_EN
      if (e.ctr == 8'd0) check("ld_ready_in_run", bus.ld_ready, 0);
`endif
      obs_r[e.ctr] = bus.R;
      obs_q[e.ctr] = bus.Q;
      busy_cnt++;
      if (abort_at >= 0 && int'(e.ctr) == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check("rst_ctr", bus.ctr, 0);
        check("rst_R", bus.R, 0);
        check("rst_Q", bus.Q, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_loaded", bus.loaded, 0);
        check("rst_ld_ready", bus.ld_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        return;
      end
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, RL);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
    check("done_pulse", bus.done, 1);
    check("done_busy", bus.busy, 0);
    check("done_ctr", bus.ctr, 0);
    check("done_R", bus.R, 0);
    check("done_Q", bus.Q, 0);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("after_done_loaded", bus.loaded, exp_next_loaded);
    check("after_done_ld_ready", bus.ld_ready, !exp_next_loaded);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seq_t r1, q1, r2, q2, r3, q3;
    vec_t tbl [5];

    r1 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
    q1 = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd4, 3'd3, 3'd2, 3'd1};
    r2 = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd7, 3'd5, 3'd1, 3'd6};
    q2 = '{3'd6, 3'd7, 3'd5, 3'd2, 3'd0, 3'd7, 3'd3, 3'd5};
    for (int i = 0; i < L; i++) begin
      r3[i] = W'($urandom_range(0, 7));
      q3[i] = W'($urandom_range(0, 7));
    end
    for (int i = 0; i < RL; i++) begin
      obs_r[i] = '1;
      obs_q[i] = '1;
    end

    // Hand-derived lane snapshots for pair 1 (lane 3 in the top bits).
    tbl[0] = '{0,  12'h001, 12'h800};
    tbl[1] = '{3,  12'h210, 12'h0C4};
    tbl[2] = '{8,  12'h101, 12'h808};
    tbl[3] = '{17, 12'h800, 12'h001};
    tbl[4] = '{18, 12'h000, 12'h000};

    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.start    = 1'b0;
    reset        = 1'b0;

    #12;
    check("reset_ctr", bus.ctr, 0);
    check("reset_R", bus.R, 0);
    check("reset_Q", bus.Q, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_loaded", bus.loaded, 0);
    check("reset_ld_ready", bus.ld_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // start with nothing loaded
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("empty_start_busy", bus.busy, 0);
      @(negedge clk);
    end
    check("empty_start_ld_ready", bus.ld_ready, 1);

    // pair 1: stalled load, ignored beats while full, full run
    load_pair(r1, q1, 1'b1, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 3'd7;
    for (int i = 0; i < 3; i++) begin
      check("full_ld_ready", bus.ld_ready, 0);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    run_pair(r1, q1, -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("tbl_R_c%0d", tbl[i].c), obs_r[tbl[i].c], tbl[i].r);
      check($sformatf("tbl_Q_c%0d", tbl[i].c), obs_q[tbl[i].c], tbl[i].q);
    end

    // pair 2: codes 5..7 kept as-is, start on the final beat ignored
    load_pair(r2, q2, 1'b0, 1'b1);
    run_pair(r2, q2, -1, 1'b0);

    // pair 3: reset at ctr=7, then a clean reload and run
    load_pair(r3, q3, 1'b1, 1'b0);
    run_pair(r3, q3, 7, 1'b0);
    check("post_abort_loaded", bus.loaded, 0);
    check("post_abort_ld_ready", bus.ld_ready, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("post_abort_start_busy", bus.busy, 0);
    load_pair(r3, q3, 1'b0, 1'b0);
    run_pair(r3, q3, -1, 1'b0);

`ifdef SEQ_FEEDER_DBUF_EN
    // load pair 2 while pair 1 runs, then start straight after done
    load_pair(r1, q1, 1'b0, 1'b0);
    fork
      run_pair(r1, q1, -1, 1'b1);
      begin
        @(negedge clk);
        check("dbuf_ld_ready_in_run", bus.ld_ready, 1);
        load_pair(r2, q2, 1'b1, 1'b0);
      end
    join
    run_pair(r2, q2, -1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
